// File: rtl/rasterizer_mem_arbiter.sv
// N-port Avalon-MM arbiter merging rasterizer stage masters onto one SDRAM port.
// Read responses return in order to the issuing port via a pending-ID FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick an eligible port, slave request held low
// ST_GRANT | owner's request forwarded to the slave until accepted/dropped
module rasterizer_mem_arbiter #(
   parameter int NUM_PORTS   = 3,
   parameter int ADDR_W      = 26,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 8,
   parameter int ARB_MODE    = 0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_PORTS*ADDR_W-1:0]      m_address,
   input  logic [NUM_PORTS-1:0]             m_read,
   input  logic [NUM_PORTS-1:0]             m_write,
   input  logic [NUM_PORTS*(DATA_W/8)-1:0]  m_byteenable,
   input  logic [NUM_PORTS*DATA_W-1:0]      m_writedata,
   output logic [NUM_PORTS-1:0]             m_waitrequest,
   output logic [DATA_W-1:0]                m_readdata,
   output logic [NUM_PORTS-1:0]             m_readdatavalid,
   output logic [ADDR_W-1:0]                s_address,
   output logic                             s_read,
   output logic                             s_write,
   output logic [DATA_W/8-1:0]              s_byteenable,
   output logic [DATA_W-1:0]                s_writedata,
   input  logic                             s_waitrequest,
   input  logic [DATA_W-1:0]                s_readdata,
   input  logic                             s_readdatavalid,
   output logic [$clog2(MAX_PENDING):0]     pending_count,
   output logic                             err_unexpected_rdv
);

   localparam int BE_W  = DATA_W / 8;
   localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int CNT_W = $clog2(MAX_PENDING) + 1;

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t            state;
   logic [ID_W-1:0]   owner;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   fifo_mem [MAX_PENDING];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [NUM_PORTS-1:0]  eligible;
   logic                  grant_found;
   logic [ID_W-1:0]       grant_id;
   logic                  granted;
   logic                  own_read;
   logic                  own_write;
   logic [ADDR_W-1:0]     own_addr;
   logic [BE_W-1:0]       own_be;
   logic [DATA_W-1:0]     own_wdata;
   logic                  accept;
   logic                  push;
   logic                  pop;

   assign fifo_full  = (count == CNT_W'(MAX_PENDING));
   assign fifo_empty = (count == '0);
   assign eligible   = m_write | (m_read & {NUM_PORTS{~fifo_full}});

   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_id    = '0;
      if (ARB_MODE == 1) begin
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
               grant_found = 1'b1;
               grant_id    = ID_W'(i);
            end
         end
      end else begin
         // search upward from rr_ptr with wrap
         for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grant_found && eligible[idx]) begin
               grant_found = 1'b1;
               grant_id    = ID_W'(idx);
            end
         end
      end
   end

   always_comb begin
      own_read  = m_read[owner];
      own_write = m_write[owner];
      own_addr  = m_address[int'(owner)*ADDR_W +: ADDR_W];
      own_be    = m_byteenable[int'(owner)*BE_W +: BE_W];
      own_wdata = m_writedata[int'(owner)*DATA_W +: DATA_W];
   end

   // reset gates the combinational paths so nothing leaks out of a stale GRANT
   assign granted      = (state == ST_GRANT) && !reset;
   assign s_read       = granted & own_read;
   assign s_write      = granted & own_write;
   assign s_address    = own_addr;
   assign s_byteenable = own_be;
   assign s_writedata  = own_wdata;

   assign accept = granted & (own_read | own_write) & ~s_waitrequest;
   assign push   = accept & own_read & ~own_write;
   assign pop    = s_readdatavalid & ~fifo_empty & ~reset;

   assign m_readdata    = s_readdata;
   assign pending_count = reset ? '0 : count;

   always_comb begin
      m_waitrequest = '1;
      if (granted) m_waitrequest[owner] = s_waitrequest;
   end

   always_comb begin
      m_readdatavalid = '0;
      if (pop) m_readdatavalid[fifo_mem[rd_ptr]] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= ST_IDLE;
         owner              <= '0;
         rr_ptr             <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         err_unexpected_rdv <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_found) begin
                  owner <= grant_id;
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (accept) begin
                  state  <= ST_IDLE;
                  rr_ptr <= (owner == ID_W'(NUM_PORTS - 1)) ? '0 : owner + ID_W'(1);
               end else if (!own_read && !own_write) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (push) begin
            fifo_mem[wr_ptr] <= owner;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (s_readdatavalid && fifo_empty) err_unexpected_rdv <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Bench for rasterizer_mem_arbiter: round-robin and fixed-priority instances share
// stimulus; a per-cycle behavioural model plus directed literal checks.
module tb_rasterizer_mem_arbiter;

   localparam int NP = 3;
   localparam int AW = 26;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MP = 8;
   localparam int CW = $clog2(MP) + 1;

   logic clock = 1'b0;
   logic reset;
   logic [NP*AW-1:0] m_address;
   logic [NP-1:0]    m_read, m_write;
   logic [NP*BW-1:0] m_byteenable;
   logic [NP*DW-1:0] m_writedata;
   logic             s_waitrequest, s_readdatavalid;
   logic [DW-1:0]    s_readdata;

   logic [NP-1:0] r_m_waitrequest, r_m_readdatavalid, f_m_waitrequest, f_m_readdatavalid;
   logic [DW-1:0] r_m_readdata, f_m_readdata, r_s_writedata, f_s_writedata;
   logic [AW-1:0] r_s_address, f_s_address;
   logic          r_s_read, r_s_write, f_s_read, f_s_write, r_err, f_err;
   logic [BW-1:0] r_s_byteenable, f_s_byteenable;
   logic [CW-1:0] r_pending_count, f_pending_count;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 1'b0;

   always #5 clock = ~clock;

   rasterizer_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP), .ARB_MODE(0)) dut_rr (
      .clock(clock), .reset(reset),
      .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_byteenable(m_byteenable), .m_writedata(m_writedata),
      .m_waitrequest(r_m_waitrequest), .m_readdata(r_m_readdata), .m_readdatavalid(r_m_readdatavalid),
      .s_address(r_s_address), .s_read(r_s_read), .s_write(r_s_write),
      .s_byteenable(r_s_byteenable), .s_writedata(r_s_writedata),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .pending_count(r_pending_count), .err_unexpected_rdv(r_err));

   rasterizer_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP), .ARB_MODE(1)) dut_fp (
      .clock(clock), .reset(reset),
      .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_byteenable(m_byteenable), .m_writedata(m_writedata),
      .m_waitrequest(f_m_waitrequest), .m_readdata(f_m_readdata), .m_readdatavalid(f_m_readdatavalid),
      .s_address(f_s_address), .s_read(f_s_read), .s_write(f_s_write),
      .s_byteenable(f_s_byteenable), .s_writedata(f_s_writedata),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .pending_count(f_pending_count), .err_unexpected_rdv(f_err));

   // model: index 0 = round-robin instance, 1 = fixed-priority instance
   bit mb_busy [2];
   int mb_owner[2];
   int mb_rr   [2];
   int mb_list [2][MP];
   int mb_len  [2];
   bit mb_err  [2];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int k);
      int o, p;
      bit rd, wr, acc, psh, pp;
      if (reset) begin
         mb_busy[k] = 0; mb_owner[k] = 0; mb_rr[k] = 0; mb_len[k] = 0; mb_err[k] = 0;
         return;
      end
      o   = mb_owner[k];
      rd  = m_read[o];
      wr  = m_write[o];
      acc = mb_busy[k] && (rd || wr) && !s_waitrequest;
      psh = acc && rd && !wr;
      pp  = s_readdatavalid && (mb_len[k] > 0);
      if (s_readdatavalid && mb_len[k] == 0) mb_err[k] = 1;
      if (mb_busy[k]) begin
         if (acc) begin
            mb_busy[k] = 0;
            mb_rr[k]   = (o + 1) % NP;
         end else if (!rd && !wr) begin
            mb_busy[k] = 0;
         end
      end else begin
         for (int i = 0; i < NP; i++) begin
            p = (k == 0) ? (mb_rr[k] + i) % NP : i;
            if (m_write[p] || (m_read[p] && mb_len[k] < MP)) begin
               mb_busy[k]  = 1;
               mb_owner[k] = p;
               break;
            end
         end
      end
      if (pp) begin
         for (int i = 0; i < MP - 1; i++) mb_list[k][i] = mb_list[k][i+1];
         mb_len[k]--;
      end
      if (psh) begin
         mb_list[k][mb_len[k]] = o;
         mb_len[k]++;
      end
   endtask

   always @(posedge clock) begin
      model_step(0);
      model_step(1);
   end

   task automatic cmp_dut(input int k, input logic sr, input logic sw, input logic [AW-1:0] sa,
                          input logic [BW-1:0] sbe, input logic [DW-1:0] swd,
                          input logic [NP-1:0] wq, input logic [NP-1:0] rdv, input logic [DW-1:0] rdat,
                          input logic [CW-1:0] pc, input logic er);
      string pf;
      logic e_sr, e_sw;
      logic [NP-1:0] e_wq, e_rdv;
      int o;
      pf    = (k == 0) ? "rr" : "fp";
      o     = mb_owner[k];
      e_sr  = 0;
      e_sw  = 0;
      e_wq  = '1;
      e_rdv = '0;
      if (!reset && mb_busy[k]) begin
         e_sr    = m_read[o];
         e_sw    = m_write[o];
         e_wq[o] = s_waitrequest;
      end
      if (!reset && s_readdatavalid && mb_len[k] > 0) e_rdv[mb_list[k][0]] = 1'b1;
      check({pf, ".s_read"}, 64'(sr), 64'(e_sr));
      check({pf, ".s_write"}, 64'(sw), 64'(e_sw));
      check({pf, ".m_waitrequest"}, 64'(wq), 64'(e_wq));
      check({pf, ".m_readdatavalid"}, 64'(rdv), 64'(e_rdv));
      check({pf, ".pending_count"}, 64'(pc), reset ? 64'd0 : 64'(mb_len[k]));
      check({pf, ".err"}, 64'(er), 64'(mb_err[k]));
      if (e_sr || e_sw) begin
         check({pf, ".s_address"}, 64'(sa), 64'(m_address[o*AW +: AW]));
         check({pf, ".s_byteenable"}, 64'(sbe), 64'(m_byteenable[o*BW +: BW]));
         check({pf, ".s_writedata"}, 64'(swd), 64'(m_writedata[o*DW +: DW]));
      end
      if (e_rdv != '0) check({pf, ".m_readdata"}, 64'(rdat), 64'(s_readdata));
   endtask

   always @(negedge clock) begin
      if (started) begin
         cmp_dut(0, r_s_read, r_s_write, r_s_address, r_s_byteenable, r_s_writedata,
                 r_m_waitrequest, r_m_readdatavalid, r_m_readdata, r_pending_count, r_err);
         cmp_dut(1, f_s_read, f_s_write, f_s_address, f_s_byteenable, f_s_writedata,
                 f_m_waitrequest, f_m_readdatavalid, f_m_readdata, f_pending_count, f_err);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      step();
      reset = 1; m_read = '0; m_write = '0; s_readdatavalid = 0; s_waitrequest = 0;
      step();
      step();
      reset = 0;
   endtask

   int gseq[16];
   int glen;
   int fgr;

   initial begin
      reset = 1; m_address = '0; m_read = '0; m_write = '0;
      m_byteenable = '1; m_writedata = '0;
      s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
      step();
      started = 1;
      @(negedge clock);
      check("rst.s_write", 64'(r_s_write), 64'd0);
      check("rst.waitreq", 64'(r_m_waitrequest), 64'b111);
      check("rst.pending", 64'(r_pending_count), 64'd0);
      step();
      reset = 0;

      // single write from port 1
      m_write = 3'b010;
      m_address[1*AW +: AW]   = 26'h0000100;
      m_writedata[1*DW +: DW] = 32'hDEADBEEF;
      @(negedge clock);
      check("wr1.bubble", 64'(r_s_write), 64'd0);
      step();
      @(negedge clock);
      check("wr1.s_write", 64'(r_s_write), 64'd1);
      check("wr1.addr", 64'(r_s_address), 64'h100);
      check("wr1.data", 64'(r_s_writedata), 64'hDEADBEEF);
      check("wr1.waitreq", 64'(r_m_waitrequest), 64'b101);
      step();
      m_write = 3'b111;
      @(negedge clock);
      check("wr1.one_cycle", 64'(r_s_write), 64'd0);
      step();
      @(negedge clock);
      check("wr1.rr_ptr2", 64'(r_m_waitrequest), 64'b011);
      step();
      m_write = '0;

      // round robin, all ports writing
      do_reset();
      m_write = 3'b111;
      glen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (r_s_write) begin
            for (int p = 0; p < NP; p++) if (!r_m_waitrequest[p]) gseq[glen] = p;
            glen++;
         end
         step();
      end
      check("rr.count", 64'(glen), 64'd6);
      for (int i = 0; i < 6; i++) check($sformatf("rr.seq%0d", i), 64'(gseq[i]), 64'(i % 3));
      m_write = '0;

      // fixed priority, ports 0 and 2 writing
      do_reset();
      m_write = 3'b101;
      fgr = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         check("fp.port2_wait", 64'(f_m_waitrequest[2]), 64'd1);
         if (f_s_write && !f_m_waitrequest[0]) fgr++;
         step();
      end
      check("fp.port0_grants", 64'(fgr), 64'd5);
      m_write = '0;

      // read routing: port 2 then port 0
      do_reset();
      m_address[2*AW +: AW] = 26'h20;
      m_address[0*AW +: AW] = 26'h40;
      m_read = 3'b100;
      step();
      @(negedge clock);
      check("rd.p2_read", 64'(r_s_read), 64'd1);
      check("rd.p2_addr", 64'(r_s_address), 64'h20);
      check("rd.p2_wait", 64'(r_m_waitrequest), 64'b011);
      step();
      m_read = 3'b001;
      @(negedge clock);
      check("rd.pend1", 64'(r_pending_count), 64'd1);
      step();
      @(negedge clock);
      check("rd.p0_wait", 64'(r_m_waitrequest), 64'b110);
      step();
      m_read = '0;
      @(negedge clock);
      check("rd.pend2", 64'(r_pending_count), 64'd2);
      for (int c = 0; c < 3; c++) step();
      s_readdatavalid = 1; s_readdata = 32'h11111111;
      @(negedge clock);
      check("rd.rdv1", 64'(r_m_readdatavalid), 64'b100);
      check("rd.data1", 64'(r_m_readdata), 64'h11111111);
      step();
      s_readdata = 32'h22222222;
      @(negedge clock);
      check("rd.pend_after1", 64'(r_pending_count), 64'd1);
      check("rd.rdv2", 64'(r_m_readdatavalid), 64'b001);
      check("rd.data2", 64'(r_m_readdata), 64'h22222222);
      step();
      s_readdatavalid = 0;
      @(negedge clock);
      check("rd.pend0", 64'(r_pending_count), 64'd0);

      // FIFO full: eight reads from port 0, then a write from port 1
      do_reset();
      m_read = 3'b001;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         step();
      end
      m_write = 3'b010;
      @(negedge clock);
      check("full.pend8", 64'(r_pending_count), 64'd8);
      check("full.p0_wait", 64'(r_m_waitrequest[0]), 64'd1);
      step();
      @(negedge clock);
      check("full.wr_granted", 64'(r_s_write), 64'd1);
      check("full.wr_wait", 64'(r_m_waitrequest), 64'b101);
      step();
      m_write = '0; s_readdatavalid = 1; s_readdata = 32'hA5A5A5A5;
      @(negedge clock);
      check("full.rdv", 64'(r_m_readdatavalid), 64'b001);
      step();
      s_readdatavalid = 0;
      @(negedge clock);
      check("full.pend7", 64'(r_pending_count), 64'd7);
      check("full.p0_still_wait", 64'(r_m_waitrequest[0]), 64'd1);
      step();
      @(negedge clock);
      check("full.unblocked", 64'(r_s_read), 64'd1);
      check("full.unblock_wait", 64'(r_m_waitrequest), 64'b110);
      step();
      m_read = '0;

      // unexpected response, then reset mid-GRANT
      do_reset();
      s_readdatavalid = 1; s_readdata = 32'h5;
      @(negedge clock);
      check("err.rdv0", 64'(r_m_readdatavalid), 64'd0);
      step();
      s_readdatavalid = 0;
      m_read = 3'b010; s_waitrequest = 1;
      @(negedge clock);
      check("err.sticky", 64'(r_err), 64'd1);
      check("err.pend0", 64'(r_pending_count), 64'd0);
      step();
      @(negedge clock);
      check("rst.mid_read", 64'(r_s_read), 64'd1);
      check("rst.mid_wait", 64'(r_m_waitrequest), 64'b111);
      step();
      reset = 1;
      @(negedge clock);
      check("rst.gated_read", 64'(r_s_read), 64'd0);
      step();
      reset = 0;
      @(negedge clock);
      check("rst.after_read", 64'(r_s_read), 64'd0);
      check("rst.after_write", 64'(r_s_write), 64'd0);
      check("rst.after_err", 64'(r_err), 64'd0);
      check("rst.after_pend", 64'(r_pending_count), 64'd0);
      step();
      m_read = '0; s_waitrequest = 0;
      for (int c = 0; c < 4; c++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rasterizer_mem_arbiter.md
Name: rasterizer_mem_arbiter

Overview:
N-port Avalon-MM arbiter that merges the rasterizer pipeline stage masters (vertex fetch, depth fetch, z-test write-back, and later a texture stage) onto a single SDRAM controller port. It generalises the current fixed scheme of one bus master per stage to a parametrised channel count with selectable arbitration mode. Read responses are routed back to the issuing port in order, using a pending-ID FIFO.

Parameters:
NUM_PORTS, 3, number of upstream master ports (2..8)
ADDR_W, 26, address width
DATA_W, 32, data width; byteenable width = DATA_W/8
MAX_PENDING, 8, maximum outstanding reads (power of 2, depth of ID FIFO)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
m_address  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
m_read  in  NUM_PORTS  per-port read request
m_write  in  NUM_PORTS  per-port write request
m_byteenable  in  NUM_PORTS*DATA_W/8  per-port byteenable
m_writedata  in  NUM_PORTS*DATA_W  per-port write data
m_waitrequest  out  NUM_PORTS  per-port waitrequest
m_readdata  out  DATA_W  read data, broadcast to all ports
m_readdatavalid  out  NUM_PORTS  one-hot; marks the port that owns m_readdata
s_address  out  ADDR_W  to SDRAM controller
s_read  out  1
s_write  out  1
s_byteenable  out  DATA_W/8
s_writedata  out  DATA_W
s_waitrequest  in  1
s_readdata  in  DATA_W
s_readdatavalid  in  1
pending_count  out  log2(MAX_PENDING)+1  outstanding reads
err_unexpected_rdv  out  1  sticky; set on s_readdatavalid while FIFO empty

Behaviour:
- Reset (synchronous, active-high) clears busy, owner, rr_ptr, FIFO and err_unexpected_rdv. During and after reset: s_read=s_write=0, m_waitrequest all 1, m_readdatavalid=0, pending_count=0. Reset mid-transfer abandons the transfer; outstanding reads are discarded.
- Eligible port i: (m_write[i]) or (m_read[i] and pending_count < MAX_PENDING).
- States: IDLE and GRANT.
  - IDLE: if any port is eligible, register owner and go to GRANT at the next edge. No slave request is driven in IDLE, so arbitration costs 1 bubble cycle.
- Grant selection:
  - ARB_MODE 0: first eligible index starting at rr_ptr, searching upward with wrap modulo NUM_PORTS.
  - ARB_MODE 1: lowest eligible index.
- GRANT state:
  - s_* outputs are driven combinationally from owner's m_* signals.
  - m_waitrequest[owner] = s_waitrequest; all other bits = 1.
  - A transfer is accepted when (s_read or s_write) and !s_waitrequest. On acceptance: go to IDLE and set rr_ptr = (owner+1) mod NUM_PORTS.
  - If owner drops both read and write before acceptance, go to IDLE without advancing rr_ptr.
- Read and write together from one master is illegal. Both are forwarded unchanged, and no FIFO push occurs.
- Pending FIFO:
  - Push owner ID on an accepted read with write low.
  - Pop on s_readdatavalid.
  - Simultaneous push and pop leaves count unchanged.
  - While full, read requests are ineligible; writes are still granted.
- Response path: m_readdata = s_readdata combinationally. m_readdatavalid = s_readdatavalid ? onehot(FIFO head) : 0, in the same cycle, with 0 added latency.
- s_readdatavalid while FIFO empty: drop the response, set err_unexpected_rdv (cleared only by reset), keep pending_count at 0.
- Minimum accepted-transfer rate is 1 per 2 cycles (GRANT then IDLE). Back-to-back on one port is not required.

Test Plan:
- Single write: port 1 writes addr 0x0000100, data 0xDEADBEEF, s_waitrequest=0 → s_write high exactly 1 cycle, 1 cycle after request; m_waitrequest[1] low that cycle; rr_ptr=2.
- Round-robin (ARB_MODE 0): all 3 ports hold write continuously → grants cycle in order 0,1,2,0,1,2; each port receives an accepted transfer every 6 cycles.
- Fixed priority (ARB_MODE 1): ports 0 and 2 request continuously → only port 0 is granted; port 2 m_waitrequest stays 1.
- Read routing: port 2 reads, then port 0 reads; slave returns 0x11111111 then 0x22222222 after 5 cycles → m_readdatavalid = 3'b100 then 3'b001 with matching data; pending_count goes 1, 2, 1, 0.
- FIFO full: MAX_PENDING=8, issue 8 reads with no responses → 9th read not granted (m_waitrequest stays 1) while a concurrent write from another port is still granted; one s_readdatavalid unblocks the read.
- Error and reset: s_readdatavalid with FIFO empty → err_unexpected_rdv=1 and m_readdatavalid=0. Reset asserted mid-GRANT while s_waitrequest=1 → next cycle s_read=s_write=0, err=0, pending_count=0.
